// File: rtl/oh2b_if.sv
// ---------------------------------------------------------------------------
// oh2b_if -- handshake bundle for the one-hot to binary encoder.
//
// Signals (direction as seen by the encoder, i.e. the slave modport):
//   In_valid    in   upstream presents a word on One_Hot
//   In_ready    out  encoder can take a word this cycle
//   One_Hot     in   O_w-bit word to encode
//   Out_valid   out  Bin/Err hold an encoded result
//   Out_ready   in   downstream takes the result this cycle
//   Bin         out  Bin_w-bit index of the (lowest) set bit
//   Err         out  word was not exactly one-hot
//   Err_cnt_clr in   synchronous clear of Err_cnt
//   Err_cnt     out  8-bit saturating count of illegal words accepted
// ---------------------------------------------------------------------------
interface oh2b_if #(
    parameter int Bin_w = 4,
    parameter int O_w   = 2**Bin_w
);
    logic             In_valid;
    logic             In_ready;
    logic [O_w-1:0]   One_Hot;
    logic             Out_valid;
    logic             Out_ready;
    logic [Bin_w-1:0] Bin;
    logic             Err;
    logic             Err_cnt_clr;
    logic [7:0]       Err_cnt;

    // Encoder side.
    modport slave (
        input  In_valid, One_Hot, Out_ready, Err_cnt_clr,
        output In_ready, Out_valid, Bin, Err, Err_cnt
    );

    // Producer/consumer side.
    modport master (
        output In_valid, One_Hot, Out_ready, Err_cnt_clr,
        input  In_ready, Out_valid, Bin, Err, Err_cnt
    );
endinterface

// File: rtl/oh2b.sv
// ---------------------------------------------------------------------------
// oh2b -- one-hot to binary encoder, single registered stage with
// valid/ready handshakes on both sides and a saturating error counter.
//
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset
//   bus  oh2b_if.slave  handshake bundle (see oh2b_if.sv)
//
// A word with zero or several bits set reports Err=1; for several bits the
// index of the lowest set bit is returned, for zero bits Bin=0.
// ---------------------------------------------------------------------------
module oh2b #(
    parameter int Bin_w = 4,
    parameter int O_w   = 2**Bin_w
) (
    input  logic   clk,
    input  logic   rst,
    oh2b_if.slave  bus
);

    // Returns {err, index}. The downward scan leaves the lowest set bit's
    // index in idx; with no bits set idx stays 0.
    function automatic logic [Bin_w:0] encode(input logic [O_w-1:0] v);
        logic [Bin_w-1:0] idx;
        int unsigned      n;
        idx = '0;
        n   = 0;
        for (int i = O_w - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = Bin_w'(i);
                n++;
            end
        end
        return {(n != 1), idx};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    logic             w_in_ready;
    logic             w_accept;
    logic             w_out_xfer;
    logic [Bin_w:0]   w_enc;

    logic             r_vld_p1;
    logic [Bin_w-1:0] r_bin_p1;
    logic             r_err_p1;
    logic [7:0]       r_err_cnt;

    // Ready looks through the output register: a word leaving this cycle
    // frees the slot for a new one, so the stage streams without bubbles.
    assign w_in_ready = !rst && (!r_vld_p1 || bus.Out_ready);
    assign w_accept   = bus.In_valid && w_in_ready;
    assign w_out_xfer = r_vld_p1 && bus.Out_ready;
    assign w_enc      = encode(bus.One_Hot);

    // ---- stage p0 -> p1: encode and register on accept ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
            r_bin_p1 <= '0;
            r_err_p1 <= 1'b0;
        end else if (w_accept) begin
            r_vld_p1 <= 1'b1;
            r_bin_p1 <= w_enc[Bin_w-1:0];
            r_err_p1 <= w_enc[Bin_w];
        end else if (w_out_xfer) begin
            r_vld_p1 <= 1'b0;
        end
    end

    // Clear takes priority over a same-cycle illegal accept.
    always_ff @(posedge clk) begin
        if (rst || bus.Err_cnt_clr) begin
            r_err_cnt <= 8'd0;
        end else if (w_accept && w_enc[Bin_w]) begin
            r_err_cnt <= sat_inc(r_err_cnt);
        end
    end

    assign bus.In_ready  = w_in_ready;
    assign bus.Out_valid = r_vld_p1;
    assign bus.Bin       = r_bin_p1;
    assign bus.Err       = r_err_p1;
    assign bus.Err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_oh2b.sv
// ---------------------------------------------------------------------------
// tb_oh2b -- directed self-checking bench for oh2b (Bin_w=4, O_w=16).
// Inputs change 1 ns after the rising edge; outputs are checked there or
// 1 ns later for combinational In_ready, never on the edge itself.
// ---------------------------------------------------------------------------
module tb_oh2b;

    logic clk;
    logic rst;

    int n_cmp;
    int n_bad;

    oh2b_if #(.Bin_w(4)) bus ();

    oh2b #(.Bin_w(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int perm [16];
    int exp_q [$];
    int sent;
    int got;
    int budget;
    int tmp;
    int j;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.In_valid    = 1'b0;
        bus.One_Hot     = '0;
        bus.Out_ready   = 1'b0;
        bus.Err_cnt_clr = 1'b0;
        cyc();
        cyc();

        // Reset state
        chk("rst_vld",   bus.Out_valid, 0);
        chk("rst_bin",   bus.Bin, 0);
        chk("rst_err",   bus.Err, 0);
        chk("rst_cnt",   bus.Err_cnt, 0);
        bus.In_valid = 1'b1;
        bus.Out_ready = 1'b1;
        #1;
        chk("rst_rdy",   bus.In_ready, 0);
        bus.In_valid = 1'b0;
        cyc();
        chk("rst_noacc", bus.Out_valid, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_rdy", bus.In_ready, 1);

        // Streaming 0x0001, 0x0080, 0x8000
        cyc();
        bus.Out_ready = 1'b1;
        bus.In_valid  = 1'b1;
        bus.One_Hot   = 16'h0001;
        #1 chk("str_rdy0", bus.In_ready, 1);
        cyc();
        chk("str_bin0", bus.Bin, 0);
        chk("str_vld0", bus.Out_valid, 1);
        chk("str_err0", bus.Err, 0);
        bus.One_Hot = 16'h0080;
        #1 chk("str_rdy1", bus.In_ready, 1);
        cyc();
        chk("str_bin1", bus.Bin, 7);
        chk("str_err1", bus.Err, 0);
        bus.One_Hot = 16'h8000;
        #1 chk("str_rdy2", bus.In_ready, 1);
        cyc();
        chk("str_bin2", bus.Bin, 15);
        chk("str_err2", bus.Err, 0);
        bus.In_valid = 1'b0;
        cyc();
        chk("str_drain_vld", bus.Out_valid, 0);
        chk("str_drain_bin", bus.Bin, 15);

        // Backpressure
        bus.In_valid = 1'b1;
        bus.One_Hot  = 16'h0010;
        cyc();
        chk("bp_bin", bus.Bin, 4);
        bus.One_Hot   = 16'h0400;
        bus.Out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_rdy", bus.In_ready, 0);
            chk("bp_hold_bin", bus.Bin, 4);
            chk("bp_hold_vld", bus.Out_valid, 1);
            cyc();
        end
        chk("bp_after_bin", bus.Bin, 4);
        bus.Out_ready = 1'b1;
        #1 chk("bp_rel_rdy", bus.In_ready, 1);
        cyc();
        chk("bp_new_bin", bus.Bin, 10);
        chk("bp_new_vld", bus.Out_valid, 1);
        bus.In_valid = 1'b0;
        cyc();
        chk("bp_drain_vld", bus.Out_valid, 0);

        // Illegal words
        bus.In_valid = 1'b1;
        bus.One_Hot  = 16'h0000;
        cyc();
        chk("ill0_bin", bus.Bin, 0);
        chk("ill0_err", bus.Err, 1);
        bus.One_Hot = 16'h0A00;
        cyc();
        chk("ill1_bin", bus.Bin, 9);
        chk("ill1_err", bus.Err, 1);
        chk("ill_cnt",  bus.Err_cnt, 2);
        // One_Hot without In_valid must be ignored
        bus.In_valid = 1'b0;
        bus.One_Hot  = 16'h0003;
        cyc();
        chk("idle_cnt", bus.Err_cnt, 2);
        chk("idle_bin", bus.Bin, 9);

        // Saturation and clear
        bus.In_valid = 1'b1;
        bus.One_Hot  = 16'h0000;
        for (int i = 0; i < 260; i++) cyc();
        chk("sat_cnt", bus.Err_cnt, 255);
        bus.Err_cnt_clr = 1'b1;
        #1 chk("clr_rdy", bus.In_ready, 1);
        cyc();
        chk("clr_cnt", bus.Err_cnt, 0);
        chk("clr_vld", bus.Out_valid, 1);
        chk("clr_err", bus.Err, 1);
        bus.Err_cnt_clr = 1'b0;
        bus.One_Hot = 16'h0006;
        cyc();
        chk("multi_bin", bus.Bin, 1);
        chk("multi_err", bus.Err, 1);
        chk("multi_cnt", bus.Err_cnt, 1);

        // Reset mid-operation
        bus.One_Hot = 16'h0020;
        cyc();
        chk("mid_bin", bus.Bin, 5);
        bus.In_valid  = 1'b0;
        bus.Out_ready = 1'b0;
        rst = 1'b1;
        #1 chk("mid_rst_rdy", bus.In_ready, 0);
        cyc();
        rst = 1'b0;
        chk("mid_vld", bus.Out_valid, 0);
        chk("mid_bin0", bus.Bin, 0);
        chk("mid_cnt", bus.Err_cnt, 0);
        #1 chk("mid_rdy", bus.In_ready, 1);
        bus.Out_ready = 1'b1;
        cyc();
        chk("mid_no_repr", bus.Out_valid, 0);

        // Random order of all legal values with random Out_ready
        for (int i = 0; i < 16; i++) perm[i] = i;
        for (int i = 15; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = perm[i];
            perm[i] = perm[j];
            perm[j] = tmp;
        end
        sent = 0;
        got = 0;
        budget = 0;
        while (got < 16 && budget < 400) begin
            bus.Out_ready = 1'($urandom_range(1, 0));
            bus.In_valid  = (sent < 16);
            bus.One_Hot   = (sent < 16) ? (16'h0001 << perm[sent]) : 16'hFFFF;
            #1;
            if (bus.Out_valid && bus.Out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rand_extra", exp_q.size(), 1);
                end else begin
                    chk("rand_bin", bus.Bin, exp_q[0]);
                    chk("rand_err", bus.Err, 0);
                    void'(exp_q.pop_front());
                end
                got++;
            end
            if (bus.In_valid && bus.In_ready) begin
                exp_q.push_back(perm[sent]);
                sent++;
            end
            cyc();
            budget++;
        end
        chk("rand_count", got, 16);
        chk("rand_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
